uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling and a
// single-entry holding register that reports framing errors and overruns.
module uart_rx #(
  parameter int BAUD_DIV = 2813,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       uartRx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        sync1_q, sync2_q;
  logic [1:0]  settle_q;
  logic        armed_q, armed_d;
  logic        deliver;
  logic        rx_s;

  assign rx_s = sync2_q;

  // A start edge is only accepted once the line has been seen high after
  // reset, so a reset in the middle of a frame cannot resync on a data bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;
    armed_d     = armed_q | (settle_q[1] & rx_s);

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (armed_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = 16'd0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_HIGH: begin
        cnt_d = 16'd0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A byte completing in the same cycle the consumer takes the old one replaces it.
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      sync1_q     <= uartRx;
      sync2_q     <= sync1_q;
      settle_q    <= {settle_q[0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences, with a scoreboard checking every byte the consumer takes.
module tb_uart_rx;

  localparam int BAUD = 64;
  localparam int HALF = 32;
  // Start bit driven at cycle S appears as rx_valid/pulses after posedge S+LAT.
  localparam int LAT  = 3 + HALF + 9 * BAUD;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       uartRx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int assertCount = 0;
  int failCount   = 0;
  int cyc = 0;
  int startCyc;
  int validRises = 0, errCycles = 0, ovrCycles = 0;
  int riseCyc, errCyc, ovrCyc;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         period;
    logic       readyHeld;
    logic       expErr;
  } vec_t;
  vec_t vecs [8];

  uart_rx #(.BAUD_DIV(BAUD), .HALF_DIV(HALF)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .uartRx   (uartRx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Observes outputs on the falling edge and checks each consumer transfer.
  task automatic monitorLoop();
    logic prevValid = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (rx_valid && !prevValid) begin
        validRises++;
        riseCyc = cyc;
      end
      if (frame_err) begin
        errCycles++;
        errCyc = cyc;
      end
      if (overrun) begin
        ovrCycles++;
        ovrCyc = cyc;
      end
      if (rx_valid && rx_ready) begin
        checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) checkOutput("xfer_data", 32'(rx_data), 32'(sb.pop_front()));
      end
      prevValid = rx_valid;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int period,
                               input int readyAt, input int resetAt);
    logic [9:0] bits;
    bits = {stopBit, data, 1'b0};
    for (int k = 0; k < 10 * period; k++) begin
      @(posedge sys_clk);
      #1;
      if (k == 0) startCyc = cyc;
      uartRx = bits[k / period];
      if (readyAt >= 0) begin
        if (k == readyAt) rx_ready = 1'b1;
        else if (k == readyAt + 1) rx_ready = 1'b0;
      end
      if (resetAt >= 0) begin
        if (k == resetAt) rst_n = 1'b0;
        else if (k == resetAt + 1) begin
          rst_n = 1'b1;
          sb.delete();
          checkOutput("midreset_valid", 32'(rx_valid), 32'd0);
          checkOutput("midreset_data", 32'(rx_data), 32'h00);
          checkOutput("midreset_ferr", 32'(frame_err), 32'd0);
          checkOutput("midreset_ovr", 32'(overrun), 32'd0);
        end
      end
    end
  endtask

  task automatic drain();
    @(posedge sys_clk);
    #1 rx_ready = 1'b1;
    @(posedge sys_clk);
    #1 rx_ready = 1'b0;
    checkOutput("valid_after_xfer", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    int v, e, o;
    vecs[0] = '{8'h5A, 1'b1, 64, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 62, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 66, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 66, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 62, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b0, 64, 1'b0, 1'b1};
    vecs[6] = '{8'h3C, 1'b1, 64, 1'b0, 1'b0};
    vecs[7] = '{8'hC6, 1'b1, 64, 1'b1, 1'b0};

    rst_n = 1'b0;
    uartRx = 1'b1;
    rx_ready = 1'b0;
    fork
      monitorLoop();
    join_none
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'h00);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge sys_clk);

    // 0x55 held until the consumer takes it.
    sb.push_back(8'h55);
    v = validRises;
    applyStimulus(8'h55, 1'b1, BAUD, -1, -1);
    checkOutput("x55_rises", 32'(validRises - v), 32'd1);
    checkOutput("x55_latency", 32'(riseCyc - startCyc), 32'(LAT));
    checkOutput("x55_data", 32'(rx_data), 32'h55);
    repeat (50) @(posedge sys_clk);
    #1;
    checkOutput("x55_hold_valid", 32'(rx_valid), 32'd1);
    checkOutput("x55_hold_data", 32'(rx_data), 32'h55);
    drain();

    // Short low glitch is rejected without any output activity.
    v = validRises;
    e = errCycles;
    @(posedge sys_clk);
    #1 uartRx = 1'b0;
    repeat (20) @(posedge sys_clk);
    #1 uartRx = 1'b1;
    repeat (100) @(posedge sys_clk);
    checkOutput("glitch_rises", 32'(validRises - v), 32'd0);
    checkOutput("glitch_ferr", 32'(errCycles - e), 32'd0);

    for (int i = 0; i < 8; i++) begin
      rx_ready = vecs[i].readyHeld;
      v = validRises;
      e = errCycles;
      if (!vecs[i].expErr) sb.push_back(vecs[i].data);
      applyStimulus(vecs[i].data, vecs[i].stopBit, vecs[i].period, -1, -1);
      if (vecs[i].expErr) begin
        repeat (3 * BAUD) @(posedge sys_clk);
        #1 uartRx = 1'b1;
        repeat (5) @(posedge sys_clk);
        checkOutput($sformatf("vec%0d_err_latency", i), 32'(errCyc - startCyc), 32'(LAT));
      end else begin
        checkOutput($sformatf("vec%0d_latency", i), 32'(riseCyc - startCyc), 32'(LAT));
      end
      checkOutput($sformatf("vec%0d_ferr_cycles", i), 32'(errCycles - e), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d_rises", i), 32'(validRises - v), 32'(!vecs[i].expErr));
      if (!vecs[i].expErr && !vecs[i].readyHeld) begin
        #1;
        checkOutput($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].data));
        drain();
      end else begin
        #1;
        checkOutput($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'd0);
      end
      rx_ready = 1'b0;
      repeat (5) @(posedge sys_clk);
    end

    // Back-to-back with a full register: second byte dropped with one overrun.
    sb.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, BAUD, -1, -1);
    v = validRises;
    o = ovrCycles;
    applyStimulus(8'h3C, 1'b1, BAUD, -1, -1);
    #1;
    checkOutput("ovr_cycles", 32'(ovrCycles - o), 32'd1);
    checkOutput("ovr_latency", 32'(ovrCyc - startCyc), 32'(LAT));
    checkOutput("ovr_keep_data", 32'(rx_data), 32'hA5);
    checkOutput("ovr_no_rise", 32'(validRises - v), 32'd0);
    drain();

    // Consumer takes the old byte in the very cycle the new one completes.
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    applyStimulus(8'hA5, 1'b1, BAUD, -1, -1);
    o = ovrCycles;
    applyStimulus(8'h3C, 1'b1, BAUD, LAT - 1, -1);
    #1;
    checkOutput("swap_no_ovr", 32'(ovrCycles - o), 32'd0);
    checkOutput("swap_valid", 32'(rx_valid), 32'd1);
    checkOutput("swap_data", 32'(rx_data), 32'h3C);
    drain();

    // Reset during bit 4 of a low-data frame, then a clean 0x0F.
    applyStimulus(8'hC3, 1'b1, BAUD, -1, -1);
    #1;
    checkOutput("pre_reset_data", 32'(rx_data), 32'hC3);
    v = validRises;
    e = errCycles;
    applyStimulus(8'h00, 1'b1, BAUD, -1, 350);
    repeat (10) @(posedge sys_clk);
    checkOutput("abort_rises", 32'(validRises - v), 32'd0);
    checkOutput("abort_ferr", 32'(errCycles - e), 32'd0);
    sb.push_back(8'h0F);
    applyStimulus(8'h0F, 1'b1, BAUD, -1, -1);
    #1;
    checkOutput("x0f_latency", 32'(riseCyc - startCyc), 32'(LAT));
    checkOutput("x0f_data", 32'(rx_data), 32'h0F);
    drain();

    repeat (5) @(posedge sys_clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
